// File: rtl/lrn_window_mapper_if.sv
// LRN window mapper bus: configuration, datapath handshakes, strobes.
// Ports: master = controller/datapath side, slave = mapper side.
interface lrn_window_mapper_if #(
    parameter int N_WIDTH        = 2,
    parameter int M_WIDTH        = 4,
    parameter int E_WIDTH        = 4,
    parameter int F_WIDTH        = 4,
    parameter int V_WIDTH        = 2,
    parameter int ADDR_BUS_WIDTH = 20
);
    logic                      start_normalization;
    logic [N_WIDTH-1:0]        dim4;
    logic [M_WIDTH-1:0]        dim3;
    logic [E_WIDTH-1:0]        dim2;
    logic [F_WIDTH-1:0]        dim1;
    logic [V_WIDTH-1:0]        padding_num;
    logic                      layout;
    logic [ADDR_BUS_WIDTH-1:0] rd_base;
    logic [ADDR_BUS_WIDTH-1:0] wr_base;
    logic                      full_flag;
    logic                      div_out_valid;
    logic                      normalized_window_rr;
    logic [ADDR_BUS_WIDTH-1:0] r_addr;
    logic                      r_enable;
    logic                      pad_slot;
    logic [ADDR_BUS_WIDTH-1:0] w_addr;
    logic                      w_enable;
    logic                      busy;
    logic                      normalized_layer;

    modport master (
        output start_normalization,
        output dim4, dim3, dim2, dim1,
        output padding_num, layout,
        output rd_base, wr_base,
        output full_flag, div_out_valid,
        output normalized_window_rr,
        input  r_addr, r_enable, pad_slot,
        input  w_addr, w_enable,
        input  busy, normalized_layer
    );

    modport slave (
        input  start_normalization,
        input  dim4, dim3, dim2, dim1,
        input  padding_num, layout,
        input  rd_base, wr_base,
        input  full_flag, div_out_valid,
        input  normalized_window_rr,
        output r_addr, r_enable, pad_slot,
        output w_addr, w_enable,
        output busy, normalized_layer
    );
endinterface

// File: rtl/lrn_window_mapper.sv
// LRN window mapper: walks an NxMxExF tensor per spatial position,
// streams padded channel reads, one write per divider result.
// Ports: core_clk, reset (sync, active-high), bus (slave modport);
// optional perf_cycles/perf_stall with LRN_MAP_PERF_CNT_EN defined.
module lrn_window_mapper #(
    parameter int N_WIDTH        = 2,
    parameter int M_WIDTH        = 4,
    parameter int E_WIDTH        = 4,
    parameter int F_WIDTH        = 4,
    parameter int V_WIDTH        = 2,
    parameter int ADDR_BUS_WIDTH = 20,
    parameter int PERF_WIDTH     = 32
) (
    input  logic                  core_clk,
    input  logic                  reset,
`ifdef LRN_MAP_PERF_CNT_EN
    output logic [PERF_WIDTH-1:0] perf_cycles,
    output logic [PERF_WIDTH-1:0] perf_stall,
`endif
    lrn_window_mapper_if.slave    bus
);
    localparam int IW = N_WIDTH + M_WIDTH
                      + E_WIDTH + F_WIDTH;
    localparam int XW = IW + ADDR_BUS_WIDTH;
    localparam int SW = M_WIDTH + V_WIDTH + 1;
    localparam int AW = ADDR_BUS_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT_FULL,
        S_WRITE,
        S_WAIT_RR,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [N_WIDTH-1:0] r_dim4;
    logic [M_WIDTH-1:0] r_dim3;
    logic [E_WIDTH-1:0] r_dim2;
    logic [F_WIDTH-1:0] r_dim1;
    logic [V_WIDTH-1:0] r_pad;
    logic               r_layout;
    logic [AW-1:0]      r_rd_base;
    logic [AW-1:0]      r_wr_base;
    logic               r_zero;

    logic [N_WIDTH-1:0] r_n;
    logic [E_WIDTH-1:0] r_e;
    logic [F_WIDTH-1:0] r_f;
    logic [SW-1:0]      r_slot;
    logic [M_WIDTH-1:0] r_wcnt;

    logic [N_WIDTH-1:0] w_n_nxt;
    logic [E_WIDTH-1:0] w_e_nxt;
    logic [F_WIDTH-1:0] w_f_nxt;
    logic [SW-1:0]      w_slot_nxt;
    logic [M_WIDTH-1:0] w_wcnt_nxt;

    logic [AW-1:0]      r_rd_addr;
    logic               r_rd_en;
    logic               r_pad_slot;
    logic [AW-1:0]      r_wr_addr;
    logic               r_wr_en;
    logic               r_busy;
    logic               r_done;

    // Configuration seen by the read-slot logic: the live inputs
    // while idle (the first slot is issued off the start edge),
    // the latched copy afterwards.
    logic [N_WIDTH-1:0] w_dim4;
    logic [M_WIDTH-1:0] w_dim3;
    logic [E_WIDTH-1:0] w_dim2;
    logic [F_WIDTH-1:0] w_dim1;
    logic [V_WIDTH-1:0] w_pad;
    logic               w_layout;
    logic [AW-1:0]      w_rd_base;

    logic               w_start;
    logic               w_zero_cfg;
    logic [SW-1:0]      w_slots;
    logic               w_last_pos;
    logic               w_rd_go;
    logic               w_rd_pad;
    logic [M_WIDTH-1:0] w_rd_m;
    logic [AW-1:0]      w_rd_addr;
    logic               w_wr_go;
    logic [AW-1:0]      w_wr_addr;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    function automatic logic [AW-1:0] addr_of(
        input logic [AW-1:0]      base,
        input logic [N_WIDTH-1:0] n,
        input logic [M_WIDTH-1:0] m,
        input logic [E_WIDTH-1:0] e,
        input logic [F_WIDTH-1:0] f,
        input logic [M_WIDTH-1:0] dm,
        input logic [E_WIDTH-1:0] de,
        input logic [F_WIDTH-1:0] df,
        input logic               lay
    );
        logic [XW-1:0] x_idx;
        if (lay) begin
            x_idx = ((XW'(n) * XW'(de) + XW'(e))
                  * XW'(df) + XW'(f))
                  * XW'(dm) + XW'(m);
        end else begin
            x_idx = ((XW'(n) * XW'(dm) + XW'(m))
                  * XW'(de) + XW'(e))
                  * XW'(df) + XW'(f);
        end
        // Sum at full width, keep the low bits: wraps silently.
        x_idx = x_idx + XW'(base);
        return x_idx[AW-1:0];
    endfunction

    assign w_start = (r_state == S_IDLE)
                   && bus.start_normalization;

    assign w_zero_cfg = (bus.dim4 == '0)
                     || (bus.dim3 == '0)
                     || (bus.dim2 == '0)
                     || (bus.dim1 == '0);

    always_comb begin
        w_dim4    = r_dim4;
        w_dim3    = r_dim3;
        w_dim2    = r_dim2;
        w_dim1    = r_dim1;
        w_pad     = r_pad;
        w_layout  = r_layout;
        w_rd_base = r_rd_base;
        if (r_state == S_IDLE) begin
            w_dim4    = bus.dim4;
            w_dim3    = bus.dim3;
            w_dim2    = bus.dim2;
            w_dim1    = bus.dim1;
            w_pad     = bus.padding_num;
            w_layout  = bus.layout;
            w_rd_base = bus.rd_base;
        end
    end

    assign w_slots = SW'(w_dim3)
                   + (SW'(w_pad) << 1);

    assign w_last_pos =
        (r_n == r_dim4 - N_WIDTH'(1))
     && (r_e == r_dim2 - E_WIDTH'(1))
     && (r_f == r_dim1 - F_WIDTH'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_wcnt_nxt  = r_wcnt;
        w_n_nxt     = r_n;
        w_e_nxt     = r_e;
        w_f_nxt     = r_f;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start_normalization) begin
                    w_slot_nxt = '0;
                    w_wcnt_nxt = '0;
                    w_n_nxt    = '0;
                    w_e_nxt    = '0;
                    w_f_nxt    = '0;
                    w_state_nxt = w_zero_cfg
                                ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (r_slot == w_slots - SW'(1)) begin
                    w_state_nxt = S_WAIT_FULL;
                end else begin
                    w_slot_nxt = r_slot + SW'(1);
                end
            end
            S_WAIT_FULL: begin
                if (bus.full_flag) begin
                    w_state_nxt = S_WRITE;
                    w_wcnt_nxt  = '0;
                end
            end
            S_WRITE: begin
                if (bus.div_out_valid) begin
                    w_wcnt_nxt = r_wcnt + M_WIDTH'(1);
                    if (r_wcnt == r_dim3 - M_WIDTH'(1)) begin
                        w_state_nxt = S_WAIT_RR;
                    end
                end
            end
            S_WAIT_RR: begin
                if (bus.normalized_window_rr) begin
                    if (w_last_pos) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_READ;
                        w_slot_nxt  = '0;
                        if (r_f == r_dim1 - F_WIDTH'(1)) begin
                            w_f_nxt = '0;
                            if (r_e == r_dim2 - E_WIDTH'(1)) begin
                                w_e_nxt = '0;
                                w_n_nxt = r_n + N_WIDTH'(1);
                            end else begin
                                w_e_nxt = r_e + E_WIDTH'(1);
                            end
                        end else begin
                            w_f_nxt = r_f + F_WIDTH'(1);
                        end
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are registered off the next-state values so each
    // slot is visible in the same cycle the FSM sits on it.
    assign w_rd_go  = (w_state_nxt == S_READ);
    assign w_rd_pad = (w_slot_nxt < SW'(w_pad))
                   || (w_slot_nxt >= SW'(w_pad)
                                   + SW'(w_dim3));
    assign w_rd_m   = M_WIDTH'(w_slot_nxt - SW'(w_pad));

    assign w_rd_addr = addr_of(w_rd_base, w_n_nxt,
                               w_rd_m, w_e_nxt, w_f_nxt,
                               w_dim3, w_dim2, w_dim1,
                               w_layout);

    assign w_wr_go   = (r_state == S_WRITE)
                    && bus.div_out_valid;
    assign w_wr_addr = addr_of(r_wr_base, r_n,
                               r_wcnt, r_e, r_f,
                               r_dim3, r_dim2, r_dim1,
                               r_layout);

    // A zero-dim layer spends one busy cycle in DONE and pulses
    // on the way out; a normal layer pulses on entry to DONE.
    assign w_busy_nxt =
        (w_state_nxt == S_READ)
     || (w_state_nxt == S_WAIT_FULL)
     || (w_state_nxt == S_WRITE)
     || (w_state_nxt == S_WAIT_RR)
     || ((r_state == S_IDLE) && (w_state_nxt == S_DONE));

    assign w_done_nxt =
        ((r_state == S_WAIT_RR) && (w_state_nxt == S_DONE))
     || ((r_state == S_DONE) && r_zero);

    always_ff @(posedge core_clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_dim4     <= '0;
            r_dim3     <= '0;
            r_dim2     <= '0;
            r_dim1     <= '0;
            r_pad      <= '0;
            r_layout   <= 1'b0;
            r_rd_base  <= '0;
            r_wr_base  <= '0;
            r_zero     <= 1'b0;
            r_n        <= '0;
            r_e        <= '0;
            r_f        <= '0;
            r_slot     <= '0;
            r_wcnt     <= '0;
            r_rd_addr  <= '0;
            r_rd_en    <= 1'b0;
            r_pad_slot <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_n     <= w_n_nxt;
            r_e     <= w_e_nxt;
            r_f     <= w_f_nxt;
            r_slot  <= w_slot_nxt;
            r_wcnt  <= w_wcnt_nxt;
            if (w_start) begin
                r_dim4    <= bus.dim4;
                r_dim3    <= bus.dim3;
                r_dim2    <= bus.dim2;
                r_dim1    <= bus.dim1;
                r_pad     <= bus.padding_num;
                r_layout  <= bus.layout;
                r_rd_base <= bus.rd_base;
                r_wr_base <= bus.wr_base;
                r_zero    <= w_zero_cfg;
            end
            r_rd_en    <= w_rd_go && !w_rd_pad;
            r_pad_slot <= w_rd_go && w_rd_pad;
            if (w_rd_go && !w_rd_pad) begin
                r_rd_addr <= w_rd_addr;
            end
            r_wr_en <= w_wr_go;
            if (w_wr_go) begin
                r_wr_addr <= w_wr_addr;
            end
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    assign bus.r_addr           = r_rd_addr;
    assign bus.r_enable         = r_rd_en;
    assign bus.pad_slot         = r_pad_slot;
    assign bus.w_addr           = r_wr_addr;
    assign bus.w_enable         = r_wr_en;
    assign bus.busy             = r_busy;
    assign bus.normalized_layer = r_done;

`ifdef LRN_MAP_PERF_CNT_EN
    logic [PERF_WIDTH-1:0] r_perf_cycles;
    logic [PERF_WIDTH-1:0] r_perf_stall;
    logic                  w_stall;

    assign w_stall = (r_state == S_WAIT_FULL)
                  || (r_state == S_WAIT_RR)
                  || ((r_state == S_WRITE)
                      && !bus.div_out_valid);

    always_ff @(posedge core_clk) begin
        if (reset || w_start) begin
            r_perf_cycles <= '0;
            r_perf_stall  <= '0;
        end else begin
            if (r_busy && (r_perf_cycles != '1)) begin
                r_perf_cycles <= r_perf_cycles
                               + PERF_WIDTH'(1);
            end
            if (w_stall && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall
                              + PERF_WIDTH'(1);
            end
        end
    end

    assign perf_cycles = r_perf_cycles;
    assign perf_stall  = r_perf_stall;
`endif
endmodule

// File: tb/tb_lrn_window_mapper.sv
// Directed bench for lrn_window_mapper: layouts, padding, batches,
// ignored handshakes, zero dims, mid-run reset, optional perf counters.
module tb_lrn_window_mapper;
    localparam int NW = 2;
    localparam int MW = 4;
    localparam int EW = 4;
    localparam int FW = 4;
    localparam int VW = 2;
    localparam int AW = 20;

    logic core_clk = 1'b0;
    logic reset    = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 core_clk = ~core_clk;

    lrn_window_mapper_if #(
        .N_WIDTH(NW), .M_WIDTH(MW), .E_WIDTH(EW),
        .F_WIDTH(FW), .V_WIDTH(VW), .ADDR_BUS_WIDTH(AW)
    ) bus ();

`ifdef LRN_MAP_PERF_CNT_EN
    logic [31:0] perf_cycles;
    logic [31:0] perf_stall;
`endif

    lrn_window_mapper #(
        .N_WIDTH(NW), .M_WIDTH(MW), .E_WIDTH(EW),
        .F_WIDTH(FW), .V_WIDTH(VW), .ADDR_BUS_WIDTH(AW),
        .PERF_WIDTH(32)
    ) dut (
        .core_clk(core_clk),
        .reset(reset),
`ifdef LRN_MAP_PERF_CNT_EN
        .perf_cycles(perf_cycles),
        .perf_stall(perf_stall),
`endif
        .bus(bus)
    );

    int          rd_q[$];
    int          rd_c[$];
    int          wr_q[$];
    int          wr_c[$];
    logic [63:0] re_log;
    logic [63:0] ps_log;
    logic [AW-1:0] ra_log [0:63];
    int          done_cyc;
    int          done_cnt;
    int          busy_cnt;
    bit          tmo;

    task automatic idle_inputs();
        bus.start_normalization  = 1'b0;
        bus.full_flag            = 1'b0;
        bus.div_out_valid        = 1'b0;
        bus.normalized_window_rr = 1'b0;
    endtask

    // Acts as the datapath: dv and rr held high, full raised
    // fdel cycles after the read slots end (or always if early).
    task automatic run(input int n, input int m,
                       input int e, input int f,
                       input int p, input int lay,
                       input int rb, input int wb,
                       input int fdel, input bit early,
                       input bit poke, input int maxc);
        int idle;
        rd_q.delete(); rd_c.delete();
        wr_q.delete(); wr_c.delete();
        re_log = '0; ps_log = '0;
        done_cyc = -1; done_cnt = 0;
        busy_cnt = 0; tmo = 1'b0; idle = 0;
        bus.dim4        = NW'(n);
        bus.dim3        = MW'(m);
        bus.dim2        = EW'(e);
        bus.dim1        = FW'(f);
        bus.padding_num = VW'(p);
        bus.layout      = lay[0];
        bus.rd_base     = AW'(rb);
        bus.wr_base     = AW'(wb);
        bus.start_normalization  = 1'b1;
        bus.full_flag            = early;
        bus.div_out_valid        = 1'b1;
        bus.normalized_window_rr = 1'b1;
        @(posedge core_clk); #1;
        bus.start_normalization = 1'b0;
        for (int c = 1; c <= maxc; c++) begin
            if (bus.r_enable) begin
                rd_q.push_back(int'(bus.r_addr));
                rd_c.push_back(c);
            end
            if (bus.w_enable) begin
                wr_q.push_back(int'(bus.w_addr));
                wr_c.push_back(c);
            end
            if (c < 64) begin
                re_log[c] = bus.r_enable;
                ps_log[c] = bus.pad_slot;
                ra_log[c] = bus.r_addr;
            end
            if (bus.busy) busy_cnt++;
            if (bus.normalized_layer) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (bus.r_enable || bus.pad_slot) idle = 0;
            else idle++;
            bus.full_flag = early || (idle > fdel);
            bus.start_normalization = poke && (c == 2);
            bus.dim4 = (poke && (c == 2)) ? '0 : NW'(n);
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
            @(posedge core_clk); #1;
        end
        if (done_cyc < 0) tmo = 1'b1;
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.dim4 = '0; bus.dim3 = '0;
        bus.dim2 = '0; bus.dim1 = '0;
        bus.padding_num = '0; bus.layout = 1'b0;
        bus.rd_base = '0; bus.wr_base = '0;
        reset = 1'b1;
        repeat (3) @(posedge core_clk);
        #1;
        n_checks++;
        if ({bus.r_addr, bus.r_enable, bus.pad_slot,
             bus.w_addr, bus.w_enable, bus.busy,
             bus.normalized_layer} !== 45'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: got ra=%h re=%b ps=%b wa=%h we=%b busy=%b done=%b want all 0",
                     bus.r_addr, bus.r_enable, bus.pad_slot,
                     bus.w_addr, bus.w_enable, bus.busy,
                     bus.normalized_layer);
        end
        reset = 1'b0;
        repeat (2) @(posedge core_clk);
        #1;
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle_busy: got %b want 0",
                     bus.busy);
        end
    endtask

    task automatic test_channel_first();
        int er[8];
        int ew[4];
        er = '{0, 4, 8, 12, 1, 5, 9, 13};
        ew = '{'h100, 'h104, 'h108, 'h10C};
        run(1, 4, 2, 2, 0, 0, 0, 'h100, 0, 0, 0, 200);
        n_checks++;
        if (tmo !== 1'b0) begin
            n_errors++;
            $display("FAIL cf_timeout: no done within budget");
        end
        n_checks++;
        if (rd_q.size() != 16 || wr_q.size() != 16) begin
            n_errors++;
            $display("FAIL cf_counts: got rd=%0d wr=%0d want 16 16",
                     rd_q.size(), wr_q.size());
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (rd_q[i] !== er[i]) begin
                n_errors++;
                $display("FAIL cf_read%0d: got %h want %h",
                         i, rd_q[i], er[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (wr_q[i] !== ew[i]) begin
                n_errors++;
                $display("FAIL cf_write%0d: got %h want %h",
                         i, wr_q[i], ew[i]);
            end
        end
        n_checks++;
        if (rd_c[0] != 1 || wr_c[0] != 7 || rd_c[4] != 11) begin
            n_errors++;
            $display("FAIL cf_timing: got rd0@%0d wr0@%0d rd4@%0d want 1 7 11",
                     rd_c[0], wr_c[0], rd_c[4]);
        end
        n_checks++;
        if (done_cnt != 1 || done_cyc != 41) begin
            n_errors++;
            $display("FAIL cf_done: got %0d pulses @%0d want 1 @41",
                     done_cnt, done_cyc);
        end
    endtask

    task automatic test_channel_last();
        run(1, 4, 2, 2, 0, 1, 0, 'h100, 0, 0, 0, 200);
        n_checks++;
        if (tmo !== 1'b0 || rd_q.size() != 16) begin
            n_errors++;
            $display("FAIL cl_run: got tmo=%b rd=%0d want 0 16",
                     tmo, rd_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rd_q[4 + i] !== 4 + i ||
                wr_q[4 + i] !== 'h104 + i) begin
                n_errors++;
                $display("FAIL cl_pos1_%0d: got rd=%h wr=%h want %h %h",
                         i, rd_q[4 + i], wr_q[4 + i],
                         4 + i, 'h104 + i);
            end
        end
        n_checks++;
        if (rd_q[8] !== 8 || rd_q[12] !== 12) begin
            n_errors++;
            $display("FAIL cl_e1: got %h %h want 8 c",
                     rd_q[8], rd_q[12]);
        end
    endtask

    task automatic test_padding();
        logic [5:0] en0, ps0, en1, ps1;
        int wpos0;
        run(1, 4, 2, 2, 1, 0, 0, 'h100, 0, 0, 0, 200);
        for (int i = 0; i < 6; i++) begin
            en0[5 - i] = re_log[1 + i];
            ps0[5 - i] = ps_log[1 + i];
            en1[5 - i] = re_log[13 + i];
            ps1[5 - i] = ps_log[13 + i];
        end
        n_checks++;
        if (en0 !== 6'b011110 || ps0 !== 6'b100001) begin
            n_errors++;
            $display("FAIL pad_pos0: got en=%b ps=%b want 011110 100001",
                     en0, ps0);
        end
        n_checks++;
        if (en1 !== 6'b011110 || ps1 !== 6'b100001) begin
            n_errors++;
            $display("FAIL pad_pos1: got en=%b ps=%b want 011110 100001",
                     en1, ps1);
        end
        n_checks++;
        if (ra_log[6] !== 20'hC) begin
            n_errors++;
            $display("FAIL pad_hold: got %h want c", ra_log[6]);
        end
        wpos0 = 0;
        foreach (wr_c[i]) if (wr_c[i] <= 12) wpos0++;
        n_checks++;
        if (wpos0 != 4 || wr_q.size() != 16 ||
            rd_q.size() != 16) begin
            n_errors++;
            $display("FAIL pad_counts: got w0=%0d wr=%0d rd=%0d want 4 16 16",
                     wpos0, wr_q.size(), rd_q.size());
        end
        n_checks++;
        if (done_cyc != 49 || done_cnt != 1) begin
            n_errors++;
            $display("FAIL pad_done: got @%0d x%0d want @49 x1",
                     done_cyc, done_cnt);
        end
    endtask

    task automatic test_batch();
        run(2, 4, 2, 2, 0, 0, 0, 'h200, 0, 1, 1, 400);
        n_checks++;
        if (rd_q.size() != 32 || wr_q.size() != 32) begin
            n_errors++;
            $display("FAIL batch_counts: got rd=%0d wr=%0d want 32 32",
                     rd_q.size(), wr_q.size());
        end
        n_checks++;
        if (rd_q[16] !== 16) begin
            n_errors++;
            $display("FAIL batch_n1_read: got %h want 10",
                     rd_q[16]);
        end
        n_checks++;
        if (wr_q[4] !== 'h201 || wr_q[31] !== 'h21F) begin
            n_errors++;
            $display("FAIL batch_writes: got %h %h want 201 21f",
                     wr_q[4], wr_q[31]);
        end
        n_checks++;
        if (done_cnt != 1 || done_cyc != 81) begin
            n_errors++;
            $display("FAIL batch_done: got x%0d @%0d want x1 @81",
                     done_cnt, done_cyc);
        end
    endtask

    task automatic test_zero_dim();
        run(1, 4, 0, 2, 0, 0, 0, 'h100, 0, 0, 0, 20);
        n_checks++;
        if (done_cyc != 2 || done_cnt != 1) begin
            n_errors++;
            $display("FAIL zero_done: got @%0d x%0d want @2 x1",
                     done_cyc, done_cnt);
        end
        n_checks++;
        if (rd_q.size() != 0 || wr_q.size() != 0) begin
            n_errors++;
            $display("FAIL zero_strobes: got rd=%0d wr=%0d want 0 0",
                     rd_q.size(), wr_q.size());
        end
    endtask

    task automatic test_mid_reset();
        bit found;
        int act;
        found = 1'b0;
        act = 0;
        bus.dim4 = NW'(1); bus.dim3 = MW'(4);
        bus.dim2 = EW'(2); bus.dim1 = FW'(2);
        bus.padding_num = '0; bus.layout = 1'b0;
        bus.rd_base = '0; bus.wr_base = AW'('h100);
        bus.full_flag = 1'b1;
        bus.div_out_valid = 1'b1;
        bus.normalized_window_rr = 1'b1;
        bus.start_normalization = 1'b1;
        @(posedge core_clk); #1;
        bus.start_normalization = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.w_enable) begin
                found = 1'b1;
                break;
            end
            @(posedge core_clk); #1;
        end
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL mr_reach_write: no w_enable in 40 cycles");
        end
        reset = 1'b1;
        @(posedge core_clk); #1;
        n_checks++;
        if ({bus.r_addr, bus.r_enable, bus.pad_slot,
             bus.w_addr, bus.w_enable, bus.busy,
             bus.normalized_layer} !== 45'h0) begin
            n_errors++;
            $display("FAIL mr_outputs: got ra=%h we=%b wa=%h busy=%b want all 0",
                     bus.r_addr, bus.w_enable,
                     bus.w_addr, bus.busy);
        end
        reset = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(posedge core_clk); #1;
            if (bus.normalized_layer || bus.busy ||
                bus.r_enable || bus.w_enable) act++;
        end
        n_checks++;
        if (act != 0) begin
            n_errors++;
            $display("FAIL mr_idle: got %0d active cycles want 0",
                     act);
        end
        idle_inputs();
        run(1, 4, 1, 1, 0, 0, 'hFFFFE, 'h40, 0, 0, 0, 60);
        n_checks++;
        if (rd_q[0] !== 'hFFFFE || rd_q[2] !== 0 ||
            rd_q[3] !== 1) begin
            n_errors++;
            $display("FAIL mr_wrap_reads: got %h %h %h want ffffe 0 1",
                     rd_q[0], rd_q[2], rd_q[3]);
        end
        n_checks++;
        if (wr_q[3] !== 'h43 || done_cyc != 11) begin
            n_errors++;
            $display("FAIL mr_recover: got wr3=%h done@%0d want 43 @11",
                     wr_q[3], done_cyc);
        end
    endtask

`ifdef LRN_MAP_PERF_CNT_EN
    task automatic test_perf();
        int s0;
        run(1, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0, 60);
        s0 = int'(perf_stall);
        n_checks++;
        if (perf_cycles !== 32'(busy_cnt) || busy_cnt != 10) begin
            n_errors++;
            $display("FAIL perf_cycles: got %0d busy=%0d want 10",
                     perf_cycles, busy_cnt);
        end
        n_checks++;
        if (s0 != 2) begin
            n_errors++;
            $display("FAIL perf_stall0: got %0d want 2", s0);
        end
        run(1, 4, 1, 1, 0, 0, 0, 0, 5, 0, 0, 60);
        n_checks++;
        if (int'(perf_stall) != s0 + 5) begin
            n_errors++;
            $display("FAIL perf_stall5: got %0d want %0d",
                     perf_stall, s0 + 5);
        end
        n_checks++;
        if (perf_cycles !== 32'(busy_cnt)) begin
            n_errors++;
            $display("FAIL perf_cycles5: got %0d want %0d",
                     perf_cycles, busy_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_channel_first();
        test_channel_last();
        test_padding();
        test_batch();
        test_zero_dim();
        test_mid_reset();
`ifdef LRN_MAP_PERF_CNT_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
